// File: rtl/countdown_timer_pkg.sv
// Shared types for the countdown timer: FSM state encoding.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    EXPIRED = 2'b10
  } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with programmable step, expiry pulse, sticky borrow and optional auto-reload.
// Latency: load/decrement visible 1 cycle after the sampling edge; no backpressure, inputs sampled every cycle.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH_P = 4
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               en,
  input  logic               clr,
  input  logic               load,
  input  logic [WIDTH_P-1:0] load_val,
  input  logic [WIDTH_P-1:0] dec,
  input  logic               auto_reload,
  output logic [WIDTH_P-1:0] val,
  output logic               zero,
  output logic               busy,
  output logic               expired,
  output logic               underflow
);

  state_t             state_q, state_d;
  logic [WIDTH_P-1:0] val_q, val_d;
  logic [WIDTH_P-1:0] reload_q, reload_d;
  logic               underflow_q, underflow_d;
  logic               expired_q, expired_d;

  logic               borrow;
  logic [WIDTH_P-1:0] diff;

  // Extra MSB catches the borrow when the step exceeds the current count.
  assign {borrow, diff} = {1'b0, val_q} - {1'b0, dec};

  always_comb begin
    state_d     = state_q;
    val_d       = val_q;
    reload_d    = reload_q;
    underflow_d = underflow_q;
    expired_d   = 1'b0;

    if (clr) begin
      state_d     = IDLE;
      val_d       = '0;
      underflow_d = 1'b0;
    end else if (load) begin
      val_d    = load_val;
      reload_d = load_val;
      state_d  = (load_val != '0) ? RUN : EXPIRED;
    end else if (state_q == RUN && en && dec != '0) begin
      if (!borrow && diff != '0) begin
        val_d = diff;
      end else begin
        expired_d = 1'b1;
        if (borrow) underflow_d = 1'b1;
        if (auto_reload && reload_q != '0) begin
          val_d = reload_q;
        end else begin
          val_d   = '0;
          state_d = EXPIRED;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q     <= IDLE;
      val_q       <= '0;
      reload_q    <= '0;
      underflow_q <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      val_q       <= val_d;
      reload_q    <= reload_d;
      underflow_q <= underflow_d;
      expired_q   <= expired_d;
    end
  end

  assign val       = val_q;
  assign zero      = (val_q == '0);
  assign busy      = (state_q == RUN);
  assign expired   = expired_q;
  assign underflow = underflow_q;

`ifdef ASSERT_ON
  // A back-to-back expiry pulse is only legal when the timer stayed in RUN (auto-reload).
  a_expired_gap : assert property (@(posedge clk) disable iff (!reset_L)
    (expired_q && state_q != RUN) |=> !expired_q);

  a_clr_effect : assert property (@(posedge clk) disable iff (!reset_L)
    clr |=> (val_q == '0 && !underflow_q));

  a_busy_run : assert property (@(posedge clk) busy |-> (state_q == RUN));
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Directed stimulus for countdown_timer; expected outputs queued per edge and checked by a separate monitor.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset_L, en, clr, load, auto_reload;
  logic [3:0] load_val, dec;
  logic [3:0] val;
  logic       zero, busy, expired, underflow;

  typedef struct packed {
    logic [3:0] v;
    logic       z;
    logic       b;
    logic       e;
    logic       u;
  } exp_t;

  exp_t exp_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  countdown_timer #(.WIDTH_P(4)) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .en          (en),
    .clr         (clr),
    .load        (load),
    .load_val    (load_val),
    .dec         (dec),
    .auto_reload (auto_reload),
    .val         (val),
    .zero        (zero),
    .busy        (busy),
    .expired     (expired),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int step, input logic [3:0] act, input logic [3:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s step %0d: got %0d, expected %0d", name, step, act, req);
  endtask

  // Monitor: outputs are presented every cycle; compare whenever an expectation is pending.
  initial begin
    int   step;
    exp_t x;
    step = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        chk("val",       step, val,             x.v);
        chk("zero",      step, {3'b0, zero},      {3'b0, x.z});
        chk("busy",      step, {3'b0, busy},      {3'b0, x.b});
        chk("expired",   step, {3'b0, expired},   {3'b0, x.e});
        chk("underflow", step, {3'b0, underflow}, {3'b0, x.u});
        step++;
      end
    end
  end

  // Drive one edge worth of inputs and queue the hand-computed post-edge outputs.
  task automatic cyc(input logic rl, input logic cl, input logic ld, input logic [3:0] lv,
                     input logic e, input logic [3:0] d, input logic ar,
                     input logic [3:0] xv, input logic xz, input logic xb,
                     input logic xe, input logic xu);
    exp_t x;
    reset_L = rl; clr = cl; load = ld; load_val = lv;
    en = e; dec = d; auto_reload = ar;
    @(posedge clk);
    x.v = xv; x.z = xz; x.b = xb; x.e = xe; x.u = xu;
    exp_q.push_back(x);
    #1;
  endtask

  initial begin
    reset_L = 1'b0; clr = 1'b0; load = 1'b1; load_val = 4'd7;
    en = 1'b0; dec = 4'd0; auto_reload = 1'b0;

    //   rl cl ld lv    en dec   ar   val   z  b  e  u
    // Reset held two cycles while load is asserted.
    cyc(0, 0, 1, 4'd7,  0, 4'd0, 0,  4'd0, 1, 0, 0, 0);
    cyc(0, 0, 1, 4'd7,  0, 4'd0, 0,  4'd0, 1, 0, 0, 0);
    // Exact count 9 -> 6 -> 3 -> 0, then ignored enable in EXPIRED.
    cyc(1, 0, 1, 4'd9,  0, 4'd0, 0,  4'd9, 0, 1, 0, 0);
    cyc(1, 0, 0, 4'd0,  1, 4'd3, 0,  4'd6, 0, 1, 0, 0);
    cyc(1, 0, 0, 4'd0,  1, 4'd3, 0,  4'd3, 0, 1, 0, 0);
    cyc(1, 0, 0, 4'd0,  1, 4'd3, 0,  4'd0, 1, 0, 1, 0);
    cyc(1, 0, 0, 4'd0,  1, 4'd3, 0,  4'd0, 1, 0, 0, 0);
    // Borrow: 5 - 7, underflow sticky across a later load.
    cyc(1, 0, 1, 4'd5,  0, 4'd0, 0,  4'd5, 0, 1, 0, 0);
    cyc(1, 0, 0, 4'd0,  1, 4'd7, 0,  4'd0, 1, 0, 1, 1);
    cyc(1, 0, 0, 4'd0,  0, 4'd0, 0,  4'd0, 1, 0, 0, 1);
    cyc(1, 0, 1, 4'd4,  0, 4'd0, 0,  4'd4, 0, 1, 0, 1);
    cyc(1, 0, 0, 4'd0,  0, 4'd5, 0,  4'd4, 0, 1, 0, 1);
    // Auto-reload 4 with step 2: 2, 4, 2, 4, 2 and busy stays high.
    cyc(1, 0, 1, 4'd4,  0, 4'd0, 1,  4'd4, 0, 1, 0, 1);
    cyc(1, 0, 0, 4'd0,  1, 4'd2, 1,  4'd2, 0, 1, 0, 1);
    cyc(1, 0, 0, 4'd0,  1, 4'd2, 1,  4'd4, 0, 1, 1, 1);
    cyc(1, 0, 0, 4'd0,  1, 4'd2, 1,  4'd2, 0, 1, 0, 1);
    cyc(1, 0, 0, 4'd0,  1, 4'd2, 1,  4'd4, 0, 1, 1, 1);
    cyc(1, 0, 0, 4'd0,  1, 4'd2, 1,  4'd2, 0, 1, 0, 1);
    cyc(1, 0, 0, 4'd0,  0, 4'd2, 1,  4'd2, 0, 1, 0, 1);
    // clr beats load and clears underflow; enable then has no effect.
    cyc(1, 1, 1, 4'd7,  1, 4'd1, 0,  4'd0, 1, 0, 0, 0);
    cyc(1, 0, 0, 4'd0,  1, 4'd1, 0,  4'd0, 1, 0, 0, 0);
    // Zero step holds; borrow with auto-reload gives consecutive expiry pulses.
    cyc(1, 0, 1, 4'd6,  0, 4'd0, 0,  4'd6, 0, 1, 0, 0);
    cyc(1, 0, 0, 4'd0,  1, 4'd0, 0,  4'd6, 0, 1, 0, 0);
    cyc(1, 0, 0, 4'd0,  1, 4'd7, 1,  4'd6, 0, 1, 1, 1);
    cyc(1, 0, 0, 4'd0,  1, 4'd7, 1,  4'd6, 0, 1, 1, 1);
    cyc(1, 0, 0, 4'd0,  1, 4'd7, 0,  4'd0, 1, 0, 1, 1);
    // Load of zero goes straight to EXPIRED without a pulse.
    cyc(1, 0, 1, 4'd0,  0, 4'd0, 0,  4'd0, 1, 0, 0, 1);
    cyc(1, 0, 0, 4'd0,  1, 4'd1, 0,  4'd0, 1, 0, 0, 1);
    // Reset mid-run loses the count and ignores a concurrent load.
    cyc(1, 0, 1, 4'd15, 0, 4'd0, 0,  4'd15, 0, 1, 0, 1);
    cyc(1, 0, 0, 4'd0,  1, 4'd1, 0,  4'd14, 0, 1, 0, 1);
    cyc(1, 0, 0, 4'd0,  1, 4'd1, 0,  4'd13, 0, 1, 0, 1);
    cyc(0, 0, 1, 4'd9,  1, 4'd1, 0,  4'd0, 1, 0, 0, 0);
    cyc(1, 0, 0, 4'd0,  1, 4'd1, 0,  4'd0, 1, 0, 0, 0);

    begin
      int waited;
      waited = 0;
      while (exp_q.size() != 0 && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      if (exp_q.size() != 0) begin
        chk_cnt++;
        $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
